// File: rtl/triple_sampler_pkg.sv
// Shared types and default parameters for the triple-point UART bit sampler.
package triple_sampler_pkg;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

endpackage

// File: rtl/triple_sampler_if.sv
// Line-side inputs and sample/frame outputs of triple_sampler bundled as one port.
interface triple_sampler_if;

    logic EN;
    logic RX;
    logic A;
    logic B;
    logic C;
    logic SAMPLE_VALID;
    logic FRAME_START;
    logic FRAME_DONE;
    logic FRAME_ERR;
    logic BUSY;

    modport master (
        output EN, RX,
        input  A, B, C, SAMPLE_VALID, FRAME_START, FRAME_DONE, FRAME_ERR, BUSY
    );

    modport slave (
        input  EN, RX,
        output A, B, C, SAMPLE_VALID, FRAME_START, FRAME_DONE, FRAME_ERR, BUSY
    );

endinterface

// File: rtl/triple_sampler_sync_2ff.sv
// One-bit two-flop synchronizer with a parameterized reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/triple_sampler.sv
// Serial receiver front end: finds start bits and samples each data bit at
// its quarter, half and three-quarter points for a downstream majority voter.
module triple_sampler
    import triple_sampler_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    triple_sampler_if.slave  bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] Q1      = CW'(CLKS_PER_BIT / 4);
    localparam logic [CW-1:0] Q2      = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] Q3      = CW'((3 * CLKS_PER_BIT) / 4);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_bit_idx;
    logic          w_rxs;
    logic          r_rxs_prev;
    logic          w_fall;
    logic          w_wrap;
    logic          w_frame_start;
    logic          w_frame_done;
    logic          r_a;
    logic          r_b;
    logic          r_c;
    logic          r_sample_valid;
    logic          r_stop_sample;
    logic          r_frame_err;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.RX),
        .o_q   (w_rxs)
    );

    assign w_fall = r_rxs_prev & ~w_rxs;
    assign w_wrap = (r_cnt == CNT_MAX);

    always_comb begin
        w_state_next  = r_state;
        w_frame_start = 1'b0;
        w_frame_done  = 1'b0;
        if (!bus.EN) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) w_state_next = ST_START;
                end
                ST_START: begin
                    // A line back high at mid start bit is treated as noise.
                    if (r_cnt == Q2 && w_rxs) begin
                        w_state_next = ST_IDLE;
                    end else if (w_wrap) begin
                        w_state_next  = ST_DATA;
                        w_frame_start = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_wrap && r_bit_idx == LAST_BIT) w_state_next = ST_STOP;
                end
                ST_STOP: begin
                    if (w_wrap) begin
                        w_state_next = ST_IDLE;
                        w_frame_done = 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE || w_state_next == ST_IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
            end
            if (r_state != ST_DATA) begin
                r_bit_idx <= '0;
            end else if (w_wrap) begin
                r_bit_idx <= r_bit_idx + BW'(1);
            end
        end
    end

    // Captures are gated by EN so a disable keeps the last triple intact.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rxs_prev     <= 1'b1;
            r_a            <= 1'b0;
            r_b            <= 1'b0;
            r_c            <= 1'b0;
            r_sample_valid <= 1'b0;
            r_stop_sample  <= 1'b1;
            r_frame_err    <= 1'b0;
        end else begin
            r_rxs_prev     <= w_rxs;
            r_sample_valid <= 1'b0;
            if (bus.EN && r_state == ST_DATA) begin
                if (r_cnt == Q1) r_a <= w_rxs;
                if (r_cnt == Q2) r_b <= w_rxs;
                if (r_cnt == Q3) begin
                    r_c            <= w_rxs;
                    r_sample_valid <= 1'b1;
                end
            end
            if (bus.EN && r_state == ST_STOP && r_cnt == Q2) r_stop_sample <= w_rxs;
            if (w_frame_done) r_frame_err <= ~r_stop_sample;
        end
    end

    assign bus.A            = r_a;
    assign bus.B            = r_b;
    assign bus.C            = r_c;
    assign bus.SAMPLE_VALID = r_sample_valid & bus.EN & rst_n;
    assign bus.FRAME_START  = w_frame_start & rst_n;
    assign bus.FRAME_DONE   = w_frame_done & rst_n;
    assign bus.FRAME_ERR    = (w_frame_done & rst_n) ? ~r_stop_sample : r_frame_err;
    assign bus.BUSY         = rst_n & (r_state != ST_IDLE);

endmodule

// File: tb/tb_triple_sampler.sv
// Randomized scoreboard bench: the driver builds each frame as a per-cycle line
// waveform and predicts pulses from it; a monitor pops and compares them.
module tb_triple_sampler;
    import triple_sampler_pkg::*;

    localparam int CPB = DEF_CLKS_PER_BIT;
    localparam int DB  = DEF_DATA_BITS;
    localparam int Q1  = CPB / 4;
    localparam int Q2  = CPB / 2;
    localparam int Q3  = (3 * CPB) / 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    triple_sampler_if bus();

    triple_sampler #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // kind: 0 frame start, 1 sample triple, 2 frame done
    typedef struct {
        int         kind;
        int         cyc;
        logic [2:0] abc;
        logic       err;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mon_cyc = 0;
    logic [2:0] last_abc = 3'b000;
    logic       last_err = 1'b0;

    task automatic check(input string name, input logic ok, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %0d want %0d at cycle %0d", name, act, req, mon_cyc);
        end
    endtask

    // Monitor: every cycle, retire overdue expectations and match any pulse.
    always @(negedge clk) begin
        ev_t        e;
        logic [2:0] got_p;
        logic [2:0] exp_p;
        logic       ok;
        mon_cyc++;
        while (exp_q.size() > 0 && exp_q[0].cyc < mon_cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event kind=%0d got none want cycle %0d", e.kind, e.cyc);
        end
        if (!rst_n) begin
            last_abc = 3'b000;
            last_err = 1'b0;
        end
        got_p = {bus.FRAME_START, bus.SAMPLE_VALID, bus.FRAME_DONE};
        if (got_p != 3'b000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse got pulses=%b want none at cycle %0d", got_p, mon_cyc);
            end else begin
                e = exp_q.pop_front();
                exp_p = (e.kind == 0) ? 3'b100 : (e.kind == 1) ? 3'b010 : 3'b001;
                ok = (got_p == exp_p) && (e.cyc == mon_cyc);
                if (e.kind == 1) ok = ok && ({bus.A, bus.B, bus.C} == e.abc) && (bus.FRAME_ERR == last_err);
                if (e.kind == 2) ok = ok && (bus.FRAME_ERR == e.err) && ({bus.A, bus.B, bus.C} == last_abc);
                if (!ok) begin
                    errors++;
                    $display("FAIL event got pulses=%b cyc=%0d abc=%b err=%b want pulses=%b cyc=%0d abc=%b err=%b",
                             got_p, mon_cyc, {bus.A, bus.B, bus.C}, bus.FRAME_ERR,
                             exp_p, e.cyc, (e.kind == 1) ? e.abc : last_abc,
                             (e.kind == 2) ? e.err : last_err);
                end else begin
                    $display("event kind=%0d cyc=%0d abc=%b err=%b ok", e.kind, mon_cyc,
                             {bus.A, bus.B, bus.C}, bus.FRAME_ERR);
                end
                if (e.kind == 1) last_abc = e.abc;
                if (e.kind == 2) last_err = e.err;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.RX = 1'b1;
        end
    endtask

    function automatic void push_ev(input int kind, input int cyc, input logic [2:0] abc,
                                    input logic err, input int limit);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        e.abc  = abc;
        e.err  = err;
        if (cyc < limit) exp_q.push_back(e);
    endfunction

    // abort_kind: 0 none, 1 EN drop, 2 reset, both in the middle of data bit 4.
    task automatic send_frame(input logic [15:0] data, input logic stop_v, input int glitch_bit,
                              input int glitch_q, input int abort_kind, input int tail_low);
        logic line[$];
        int   n;
        int   s;
        int   abort_idx;
        int   limit;
        int   base;
        int   busy_seen;
        n = (DB + 2) * CPB;
        for (int i = 0; i < CPB; i++) line.push_back(1'b0);
        for (int b = 0; b < DB; b++)
            for (int i = 0; i < CPB; i++) line.push_back(data[b]);
        for (int i = 0; i < CPB; i++) line.push_back(stop_v);
        if (glitch_bit >= 0) begin
            base = (glitch_bit + 1) * CPB + glitch_q + 1;
            line[base] = ~line[base];
        end
        abort_idx = (abort_kind != 0) ? 5 * CPB + CPB / 2 : n;

        @(posedge clk);
        #1;
        s = mon_cyc + 1;
        limit = (abort_kind != 0) ? s + abort_idx : 32'h7fff_ffff;
        // The line is seen 2 cycles late; counting starts the cycle after detection.
        push_ev(0, s + 2 + CPB, 3'b000, 1'b0, limit);
        for (int b = 0; b < DB; b++) begin
            base = (b + 1) * CPB + 1;
            push_ev(1, s + 4 + (b + 1) * CPB + Q3,
                    {line[base + Q1], line[base + Q2], line[base + Q3]}, 1'b0, limit);
        end
        push_ev(2, s + 2 + (DB + 2) * CPB, 3'b000, ~line[(DB + 1) * CPB + Q2 + 1], limit);
        $display("frame data=%h stop=%b glitch_bit=%0d glitch_q=%0d abort=%0d start_cyc=%0d",
                 data, stop_v, glitch_bit, glitch_q, abort_kind, s);

        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (i == abort_idx) begin
                bus.RX = 1'b1;
                if (abort_kind == 1) bus.EN = 1'b0;
                else rst_n = 1'b0;
                @(posedge clk);
                #1;
                @(negedge clk);
                check("busy_after_abort", bus.BUSY == 1'b0, int'(bus.BUSY), 0);
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                bus.EN = 1'b1;
                rst_n  = 1'b1;
                idle(6);
                return;
            end
            bus.RX = line[i];
        end

        if (tail_low > 0) begin
            // Falling edge lands in the STOP->IDLE cycle and must be ignored.
            busy_seen = 0;
            for (int i = 0; i < tail_low; i++) begin
                @(posedge clk);
                #1;
                bus.RX = 1'b0;
                @(negedge clk);
                if (i >= 3 && bus.BUSY) busy_seen++;
            end
            check("edge_at_stop_exit_ignored", busy_seen == 0, busy_seen, 0);
        end
        idle(3 + int'($urandom_range(7, 0)));
    endtask

    task automatic false_start();
        int busy_cnt;
        busy_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            bus.RX = (i < 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (bus.BUSY) busy_cnt++;
        end
        // Busy from entering START through the mid-bit check, inclusive.
        check("false_start_busy_cycles", busy_cnt == Q2 + 1, busy_cnt, Q2 + 1);
        check("false_start_idle", bus.BUSY == 1'b0, int'(bus.BUSY), 0);
        $display("false start busy_cycles=%0d", busy_cnt);
    endtask

    initial begin
        logic [15:0] d;
        int          gb;
        int          gq;
        int          pick;
        bus.EN = 1'b1;
        bus.RX = 1'b1;
        rst_n  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.RX = ~bus.RX;
            @(negedge clk);
            check("reset_outputs_zero",
                  {bus.A, bus.B, bus.C, bus.SAMPLE_VALID, bus.FRAME_START,
                   bus.FRAME_DONE, bus.FRAME_ERR, bus.BUSY} == 8'h00,
                  int'({bus.A, bus.B, bus.C, bus.SAMPLE_VALID, bus.FRAME_START,
                        bus.FRAME_DONE, bus.FRAME_ERR, bus.BUSY}), 0);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        bus.RX = 1'b1;
        idle(5);

        send_frame(16'h00A5, 1'b1, -1, 0, 0, 0);
        false_start();
        idle(4);
        d = 16'($urandom_range(255, 0)) | 16'h0004;
        send_frame(d, 1'b1, 2, Q1 + 1 - 1, 0, 0);
        send_frame(16'h003C, 1'b0, -1, 0, 0, 0);
        send_frame(16'($urandom_range(255, 0)), 1'b1, -1, 0, 1, 0);
        send_frame(16'($urandom_range(255, 0)), 1'b1, -1, 0, 0, 0);
        send_frame(16'($urandom_range(255, 0)), 1'b1, -1, 0, 2, 0);
        send_frame(16'($urandom_range(255, 0)), 1'b1, -1, 0, 0, 0);
        send_frame(16'($urandom_range(255, 0)), 1'b1, -1, 0, 0, 20);
        idle(4);

        for (int k = 0; k < 6; k++) begin
            d    = 16'($urandom_range(255, 0));
            pick = int'($urandom_range(2, 0));
            gq   = (pick == 0) ? Q1 : (pick == 1) ? Q2 : Q3;
            gb   = ($urandom_range(1, 0) != 0) ? int'($urandom_range(DB - 1, 0)) : -1;
            send_frame(d, ($urandom_range(3, 0) != 0), gb, gq, 0, 0);
        end

        idle(20);
        check("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/triple_sampler.md
TRIPLE_SAMPLER -- requirements
Module: triple_sampler

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 4..1024.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, LSB first; legal range 1..16.
REQ-003 Port clk  input  1: sole clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1: reset, synchronous and active-low.
REQ-005 Port EN  input  1: receiver enable; low forces and holds IDLE.
REQ-006 Port RX  input  1: asynchronous serial line; idles high.
REQ-007 Port A  output  1: sample at quarter-bit point Q1.
REQ-008 Port B  output  1: sample at mid-bit point Q2.
REQ-009 Port C  output  1: sample at three-quarter-bit point Q3.
REQ-010 Port SAMPLE_VALID  output  1: one-cycle pulse; A/B/C hold a new data-bit triple for the downstream 2-of-3 majority voter.
REQ-011 Port FRAME_START  output  1: one-cycle pulse on an accepted start bit.
REQ-012 Port FRAME_DONE  output  1: one-cycle pulse at end of stop bit.
REQ-013 Port FRAME_ERR  output  1: stop-bit status, valid with FRAME_DONE.
REQ-014 Port BUSY  output  1: high in any state other than IDLE.

Function
REQ-015 RX shall pass through a 2-flop synchronizer; rxs is the synchronized value, 2 cycles after RX.
REQ-016 Sample points shall be Q1=CLKS_PER_BIT/4, Q2=CLKS_PER_BIT/2, Q3=(3*CLKS_PER_BIT)/4, all integer-truncated, on bit counter cnt, which runs 0..CLKS_PER_BIT-1 and wraps.
REQ-017 The FSM shall have exactly 4 states: IDLE, START, DATA, STOP.
REQ-018 IDLE->START on a rxs high-to-low transition while EN=1; cnt shall be cleared to 0.
REQ-019 START: at cnt==Q2, rxs high is a false start -> IDLE with no pulses; otherwise, at cnt wrap -> DATA, with a FRAME_START pulse in the same cycle.
REQ-020 DATA: A, B, C shall capture rxs at Q1, Q2, Q3; SAMPLE_VALID shall pulse in the cycle after the Q3 capture.
REQ-021 A, B, C shall hold their values until the next capture.
REQ-022 After DATA_BITS bit periods, DATA->STOP at cnt wrap.
REQ-023 STOP: rxs shall be sampled at Q2.
REQ-024 At cnt wrap in STOP, FSM -> IDLE; FRAME_DONE pulses in that cycle, with FRAME_ERR = NOT(the Q2 stop sample).
REQ-025 FRAME_ERR shall hold its value until the next FRAME_DONE.
REQ-026 No SAMPLE_VALID shall be emitted for start or stop bits; exactly DATA_BITS pulses per accepted frame, spaced CLKS_PER_BIT cycles apart.
REQ-027 EN low in any state: next state IDLE, all pulses suppressed from that cycle, A/B/C/FRAME_ERR retained.
REQ-028 A falling edge that arrives in the same cycle as the STOP->IDLE transition shall not start a frame; detection shall begin on the following cycle.
REQ-029 Bit counter width shall be $clog2(CLKS_PER_BIT); bit index width shall be $clog2(DATA_BITS+1).

Reset
REQ-030 While rst_n=0 at a clock edge: state IDLE, cnt and bit index 0, synchronizer flops 1.
REQ-031 While rst_n=0, A/B/C/SAMPLE_VALID/FRAME_START/FRAME_DONE/FRAME_ERR/BUSY shall all be 0.
REQ-032 Reset mid-frame shall abandon the frame with no FRAME_DONE; reception shall resume only on a fresh falling edge after rst_n=1.

Structure
REQ-033 Package triple_sampler_pkg shall hold the state enum typedef and default CLKS_PER_BIT/DATA_BITS constants.
REQ-034 The synchronizer shall be sub-module sync_2ff (one bit, parameterized reset value); all other logic shall be in triple_sampler.

Verification
REQ-035 Reset check: rst_n=0 for 3 cycles with RX toggling -> all outputs 0, BUSY=0.
REQ-036 Clean frame 0xA5 at defaults -> FRAME_START; 8 SAMPLE_VALID pulses 16 cycles apart with A=B=C = 1,0,1,0,0,1,0,1; FRAME_DONE with FRAME_ERR=0.
REQ-037 False start: RX low for 5 cycles in IDLE -> back to IDLE, no FRAME_START, BUSY high only during the attempt.
REQ-038 Glitch: RX inverted for 1 cycle at Q1 of data bit 2 (value 1) -> A=0, B=C=1 on that pulse; other bits unaffected.
REQ-039 Stop bit driven low on byte 0x3C -> 8 correct triples; FRAME_DONE with FRAME_ERR=1.
REQ-040 EN=0 during data bit 4, and separately rst_n=0 during data bit 4 -> BUSY=0 next cycle; no further SAMPLE_VALID or FRAME_DONE; next clean frame received correctly.
